// File: rtl/ldtbl_loader.sv
// ldtbl_loader: streams host words into an external lookup table.
// Each table entry takes three host words (hi, lo, map), each written to its
// own table slot. An optional read-back pass compares the entry with the
// captured words. The first failing entry is recorded in a sticky error flag.
module ldtbl_loader #(
  parameter int DATA_W  = 32,
  parameter int LDTBL_W = 48,
  parameter int MAP_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_verify,
  input  logic [3:0]        i_base,
  input  logic [4:0]        i_count,
  input  logic              i_vld,
  output logic              o_rdy,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_exwe,
  output logic              o_exre,
  output logic [5:0]        o_exa,
  output logic [DATA_W-1:0] o_exwd,
  input  logic [DATA_W-1:0] i_exrd,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [3:0]        o_errent
);

  // Width of each half of a table entry (hi and lo).
  localparam int HALF_W = LDTBL_W / 2;
  // Bits of the hi half that appear above the lo half in the packed read-back word.
  localparam int TOP_W  = DATA_W - HALF_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_RD_TBL,
    S_RD_MAP,
    S_DONE
  } state_t;

  // Slot select bits for each write phase: hi, then lo, then map.
  function automatic logic [1:0] sel_for(input logic [1:0] phase);
    case (phase)
      2'd0:    sel_for = 2'b10;
      2'd1:    sel_for = 2'b01;
      default: sel_for = 2'b11;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        phase_q;
  logic [3:0]        entry_q;
  logic [4:0]        remain_q;
  logic              verify_q;
  logic [TOP_W-1:0]  hi_q;
  logic [HALF_W-1:0] lo_q;
  logic [MAP_W-1:0]  map_q;

  logic [4:0] count_clamp;
  logic       take_word;
  logic       advance;
  logic       last_entry;
  logic       tbl_bad;
  logic       map_bad;
  logic       mismatch;

  assign count_clamp = (i_count > 5'd16) ? 5'd16 : i_count;
  assign last_entry  = (remain_q == 5'd1);

  // Read-back comparison: the packed slot returns lo in the low bits and the
  // low byte of hi above it; the map slot must be zero above the map width.
  assign tbl_bad  = (i_exrd[HALF_W-1:0] != lo_q) || (i_exrd[DATA_W-1:HALF_W] != hi_q);
  assign map_bad  = (i_exrd[MAP_W-1:0] != map_q) || (i_exrd[DATA_W-1:MAP_W] != '0);
  assign mismatch = ((state_q == S_RD_TBL) && tbl_bad) ||
                    ((state_q == S_RD_MAP) && map_bad);

  // Status outputs are decoded directly from the state register.
  assign o_rdy  = (state_q == S_FETCH);
  assign o_busy = (state_q == S_FETCH) || (state_q == S_WRITE) ||
                  (state_q == S_RD_TBL) || (state_q == S_RD_MAP);
  assign o_done = (state_q == S_DONE);

  // Next-state logic and per-cycle event flags.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d   = state_q;
    take_word = 1'b0;
    advance   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = (count_clamp == 5'd0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        // Abort wins over a simultaneous handshake; the word is dropped.
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (i_vld) begin
          take_word = 1'b1;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (phase_q != 2'd2) begin
          state_d = S_FETCH;
        end else if (verify_q) begin
          state_d = S_RD_TBL;
        end else begin
          advance = 1'b1;
          state_d = last_entry ? S_DONE : S_FETCH;
        end
      end
      S_RD_TBL: begin
        state_d = i_abort ? S_IDLE : S_RD_MAP;
      end
      S_RD_MAP: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else begin
          advance = 1'b1;
          state_d = last_entry ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Load parameters, entry/phase tracking, captured words and error status.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the captured words are plain registers, not a memory, so they are
    // reset with everything else and never carry stale X into a comparison.
    if (!rst_n) begin
      phase_q  <= 2'd0;
      entry_q  <= 4'd0;
      remain_q <= 5'd0;
      verify_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      map_q    <= '0;
      o_err    <= 1'b0;
      o_errent <= 4'd0;
    end else begin
      if ((state_q == S_IDLE) && i_start) begin
        phase_q  <= 2'd0;
        entry_q  <= i_base;
        remain_q <= count_clamp;
        verify_q <= i_verify;
        o_err    <= 1'b0;
        o_errent <= 4'd0;
      end

      if (take_word) begin
        case (phase_q)
          2'd0:    hi_q  <= i_data[TOP_W-1:0];
          2'd1:    lo_q  <= i_data[HALF_W-1:0];
          default: map_q <= i_data[MAP_W-1:0];
        endcase
      end

      if ((state_q == S_WRITE) && !i_abort && (phase_q != 2'd2)) begin
        phase_q <= phase_q + 2'd1;
      end

      if (advance) begin
        phase_q  <= 2'd0;
        entry_q  <= entry_q + 4'd1;
        remain_q <= remain_q - 5'd1;
      end

      // Only the first failing entry of a load is recorded.
      if (mismatch) begin
        o_err <= 1'b1;
        if (!o_err) o_errent <= entry_q;
      end
    end
  end

  // Registered table strobes, address and write data; the strobes are
  // decoded from the next state so they are high exactly in their state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_exwe <= 1'b0;
      o_exre <= 1'b0;
      o_exa  <= 6'd0;
      o_exwd <= '0;
    end else begin
      o_exwe <= (state_d == S_WRITE);
      o_exre <= (state_d == S_RD_TBL) || (state_d == S_RD_MAP);
      if (take_word) begin
        o_exa  <= {entry_q, sel_for(phase_q)};
        o_exwd <= i_data;
      end else if (state_d == S_RD_TBL) begin
        o_exa <= {entry_q, 2'b00};
      end else if (state_d == S_RD_MAP) begin
        o_exa <= {entry_q, 2'b11};
      end
    end
  end

endmodule

// File: tb/tb_ldtbl_loader.sv
// tb_ldtbl_loader: randomized loads against a behavioural model of the
// expected table traffic, plus an external table model serving read-back.
module tb_ldtbl_loader;

  localparam int DATA_W  = 32;
  localparam int LDTBL_W = 48;
  localparam int MAP_W   = 12;
  localparam logic [31:0] MAP_MASK = 32'h0000_0FFF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_start, i_abort, i_verify;
  logic [3:0]        i_base;
  logic [4:0]        i_count;
  logic              i_vld;
  logic              o_rdy;
  logic [DATA_W-1:0] i_data;
  logic              o_exwe, o_exre;
  logic [5:0]        o_exa;
  logic [DATA_W-1:0] o_exwd;
  logic [DATA_W-1:0] i_exrd;
  logic              o_busy, o_done, o_err;
  logic [3:0]        o_errent;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  ldtbl_loader #(.DATA_W(DATA_W), .LDTBL_W(LDTBL_W), .MAP_W(MAP_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_verify(i_verify), .i_base(i_base), .i_count(i_count),
    .i_vld(i_vld), .o_rdy(o_rdy), .i_data(i_data),
    .o_exwe(o_exwe), .o_exre(o_exre), .o_exa(o_exa), .o_exwd(o_exwd),
    .i_exrd(i_exrd), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_errent(o_errent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External table: raw slots, map slots keep only MAP_W bits.
  logic [31:0] tbl [64];
  logic [15:0] bad_set  = 16'h0;
  logic [1:0]  bad_sel  = 2'b11;
  logic [31:0] bad_mask = 32'h0;

  always @(posedge clk) begin
    if (o_exwe) tbl[o_exa] <= (o_exa[1:0] == 2'b11) ? (o_exwd & MAP_MASK) : o_exwd;
  end

  always_comb begin
    i_exrd = tbl[o_exa];
    if (o_exa[1:0] == 2'b00) i_exrd = {tbl[{o_exa[5:2], 2'b10}][7:0], tbl[{o_exa[5:2], 2'b01}][23:0]};
    if (bad_set[o_exa[5:2]] && (o_exa[1:0] == bad_sel)) i_exrd = i_exrd ^ bad_mask;
  end

  // Strobe/done monitor, sampled on the falling edge.
  typedef struct {
    logic        we;
    logic        re;
    logic [5:0]  a;
    logic [31:0] d;
    int          c;
  } ev_t;

  ev_t ev_q[$];
  ev_t ev_mon;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  both_cnt = 0;

  always @(negedge clk) begin
    if (o_exwe || o_exre) begin
      ev_mon.we = o_exwe;
      ev_mon.re = o_exre;
      ev_mon.a  = o_exa;
      ev_mon.d  = o_exwe ? o_exwd : 32'h0;
      ev_mon.c  = cyc;
      ev_q.push_back(ev_mon);
    end
    if (o_exwe && o_exre) both_cnt++;
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  logic [31:0] wq[$];

  function automatic logic [1:0] sel_of(input int p);
    if (p == 0)      return 2'b10;
    else if (p == 1) return 2'b01;
    else             return 2'b11;
  endfunction

  task automatic fill_words(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  // Runs one load with the words in wq and checks traffic, timing and status.
  task automatic run_load(input logic [3:0] base, input logic [4:0] cnt, input logic ver,
                          input int stall_word, input int stall_len, input bit do_abort,
                          input bit spurious, input string tag);
    int eff, per, s, w, stall_cnt, n_cons, c0, n;
    bit ended, exp_err;
    logic [3:0] ent, exp_ent;
    ev_t exp_q[$];
    ev_t e;
    eff       = (cnt > 5'd16) ? 16 : int'(cnt);
    per       = ver ? 8 : 6;
    w         = 0;
    stall_cnt = 0;
    ended     = 1'b0;
    @(posedge clk); #1;
    ev_q.delete();
    done_cnt = 0;
    both_cnt = 0;
    i_start  = 1'b1; i_base = base; i_count = cnt; i_verify = ver;
    i_vld    = 1'b0; i_abort = 1'b0;
    s = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int k = 0; k < 4000 && !ended; k++) begin
      i_abort = 1'b0;
      i_vld   = 1'b0;
      i_start = spurious && (k == 1);
      if (i_start) begin
        i_base = 4'($urandom); i_count = 5'($urandom); i_verify = 1'($urandom);
      end
      if (w == stall_word && stall_cnt < stall_len) begin
        stall_cnt++;
      end else if (do_abort && w == stall_word) begin
        i_abort = 1'b1; i_vld = 1'b1; i_data = wq[w];
      end else if (w < wq.size()) begin
        i_vld = 1'b1; i_data = wq[w];
      end
      @(negedge clk);
      if (k == 0) begin
        compared++;
        if (o_err !== 1'b0) begin
          mismatched++;
          $display("FAIL %s err_clear: o_err=%b expected 0", tag, o_err);
        end
      end
      if (i_vld && o_rdy && !i_abort) w++;
      if (i_abort || !o_busy) ended = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    compared++;
    if (!ended) begin
      mismatched++;
      $display("FAIL %s timeout: load still busy after cycle budget", tag);
    end
    @(posedge clk); #1;
    i_vld = 1'b0; i_abort = 1'b0; i_start = 1'b0;

    compared++;
    if ({o_busy, o_rdy, o_exwe, o_exre, o_done} !== 5'b0) begin
      mismatched++;
      $display("FAIL %s idle_after: busy/rdy/we/re/done=%b expected 00000", tag,
               {o_busy, o_rdy, o_exwe, o_exre, o_done});
    end

    // Expected traffic, built from the words and the entry/slot rules.
    n_cons = do_abort ? stall_word : 3 * eff;
    compared++;
    if (w != n_cons) begin
      mismatched++;
      $display("FAIL %s words: consumed %0d expected %0d", tag, w, n_cons);
    end
    for (int j = 0; j < n_cons; j++) begin
      ent = base + 4'(j / 3);
      c0  = s + 1 + (j / 3) * per;
      e.we = 1'b1; e.re = 1'b0; e.a = {ent, sel_of(j % 3)}; e.d = wq[j];
      e.c  = c0 + 2 * (j % 3) + 1;
      exp_q.push_back(e);
      if (ver && (j % 3 == 2)) begin
        e.we = 1'b0; e.re = 1'b1; e.d = 32'h0;
        e.a = {ent, 2'b00}; e.c = c0 + 6; exp_q.push_back(e);
        e.a = {ent, 2'b11}; e.c = c0 + 7; exp_q.push_back(e);
      end
    end

    repeat (3) @(posedge clk);
    #1;

    compared++;
    if (ev_q.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL %s strobe_count: got %0d expected %0d", tag, ev_q.size(), exp_q.size());
    end
    n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      compared++;
      if (ev_q[i].we !== exp_q[i].we || ev_q[i].re !== exp_q[i].re ||
          ev_q[i].a !== exp_q[i].a || ev_q[i].d !== exp_q[i].d ||
          (stall_len == 0 && !do_abort && ev_q[i].c != exp_q[i].c)) begin
        mismatched++;
        $display("FAIL %s strobe[%0d]: we=%b re=%b a=%h d=%h cyc=+%0d expected we=%b re=%b a=%h d=%h cyc=+%0d",
                 tag, i, ev_q[i].we, ev_q[i].re, ev_q[i].a, ev_q[i].d, ev_q[i].c - s,
                 exp_q[i].we, exp_q[i].re, exp_q[i].a, exp_q[i].d, exp_q[i].c - s);
      end
    end

    compared++;
    if (both_cnt != 0) begin
      mismatched++;
      $display("FAIL %s we_and_re: %0d cycles with both strobes, expected 0", tag, both_cnt);
    end

    compared++;
    if (done_cnt != (do_abort ? 0 : 1)) begin
      mismatched++;
      $display("FAIL %s done_count: got %0d expected %0d", tag, done_cnt, do_abort ? 0 : 1);
    end
    if (!do_abort && stall_len == 0 && done_cnt == 1) begin
      compared++;
      if (eff > 0 && done_cyc != s + 1 + eff * per) begin
        mismatched++;
        $display("FAIL %s done_time: +%0d cycles expected +%0d", tag, done_cyc - s, 1 + eff * per);
      end else if (eff == 0 && (done_cyc - s < 1 || done_cyc - s > 2)) begin
        mismatched++;
        $display("FAIL %s done_time: +%0d cycles expected within 2", tag, done_cyc - s);
      end
    end

    if (exp_q.size() > 0) begin
      compared++;
      if (o_exa !== exp_q[exp_q.size()-1].a) begin
        mismatched++;
        $display("FAIL %s exa_hold: o_exa=%h expected %h", tag, o_exa, exp_q[exp_q.size()-1].a);
      end
      compared++;
      if (o_exwd !== wq[n_cons-1]) begin
        mismatched++;
        $display("FAIL %s exwd_hold: o_exwd=%h expected %h", tag, o_exwd, wq[n_cons-1]);
      end
    end

    exp_err = 1'b0;
    exp_ent = 4'd0;
    if (ver) begin
      for (int k = 0; k < n_cons / 3; k++) begin
        ent = base + 4'(k);
        if (bad_set[ent] && !exp_err) begin
          exp_err = 1'b1;
          exp_ent = ent;
        end
      end
    end
    compared++;
    if (o_err !== exp_err || o_errent !== exp_ent) begin
      mismatched++;
      $display("FAIL %s err: o_err=%b o_errent=%0d expected %b / %0d", tag, o_err, o_errent, exp_err, exp_ent);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b1; i_abort = 1'b0; i_verify = 1'b1;
    i_base = 4'd5; i_count = 5'd3; i_vld = 1'b1; i_data = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    compared++;
    if ({o_rdy, o_exwe, o_exre, o_exa, o_exwd, o_busy, o_done, o_err, o_errent} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: rdy=%b we=%b re=%b exa=%h exwd=%h busy=%b done=%b err=%b errent=%h expected all 0",
               o_rdy, o_exwe, o_exre, o_exa, o_exwd, o_busy, o_done, o_err, o_errent);
    end
    i_start = 1'b0; i_vld = 1'b0;
    rst_n = 1'b1;
    // i_abort in IDLE has no effect.
    @(posedge clk); #1; i_abort = 1'b1;
    @(posedge clk); #1; i_abort = 1'b0;
    compared++;
    if ({o_busy, o_done, o_rdy} !== 3'b0) begin
      mismatched++;
      $display("FAIL idle_abort: busy/done/rdy=%b expected 000", {o_busy, o_done, o_rdy});
    end
  endtask

  task automatic test_basic();
    bad_set = 16'h0;
    wq.delete();
    wq.push_back(32'h00AA_BBCC);
    wq.push_back(32'h0011_2233);
    wq.push_back(32'h0000_0ABC);
    run_load(4'd3, 5'd1, 1'b0, -1, 0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_wrap();
    fill_words(9);
    run_load(4'd14, 5'd3, 1'b0, -1, 0, 1'b0, 1'b0, "wrap");
  endtask

  task automatic test_verify();
    bad_set = 16'h0;
    fill_words(3);
    run_load(4'd3, 5'd1, 1'b1, -1, 0, 1'b0, 1'b0, "verify_one");
    for (int r = 0; r < 4; r++) begin
      logic [4:0] c;
      c = 5'($urandom_range(1, 6));
      fill_words(3 * int'(c));
      run_load(4'($urandom), c, 1'($urandom), -1, 0, 1'b0, 1'b1, "verify_rand");
    end
  endtask

  task automatic test_corrupt();
    bad_set = 16'h0004; bad_sel = 2'b11; bad_mask = 32'h0000_0020;
    fill_words(12);
    run_load(4'd0, 5'd4, 1'b1, -1, 0, 1'b0, 1'b0, "corrupt_map");
    bad_set = 16'h0;
    fill_words(3);
    run_load(4'd5, 5'd1, 1'b0, -1, 0, 1'b0, 1'b0, "err_cleared");
    for (int r = 0; r < 4; r++) begin
      logic [4:0] c;
      c        = 5'($urandom_range(1, 8));
      bad_set  = 16'($urandom);
      bad_sel  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      bad_mask = 32'd1 << $urandom_range(0, 31);
      fill_words(3 * int'(c));
      run_load(4'($urandom), c, 1'b1, -1, 0, 1'b0, 1'b0, "corrupt_rand");
    end
    bad_set = 16'h0;
  endtask

  task automatic test_stall_abort();
    fill_words(6);
    run_load(4'($urandom), 5'd2, 1'b0, 1, 5, 1'b1, 1'b0, "stall_abort");
    fill_words(6);
    run_load(4'($urandom), 5'd2, 1'b1, 4, 3, 1'b0, 1'b0, "stall_verify");
    wq.delete();
    run_load(4'($urandom), 5'd0, 1'($urandom), -1, 0, 1'b0, 1'b0, "count_zero");
  endtask

  task automatic test_reset_mid();
    bit found;
    fill_words(3);
    @(posedge clk); #1;
    i_start = 1'b1; i_base = 4'd7; i_count = 5'd2; i_verify = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0; i_vld = 1'b1; i_data = wq[0];
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (o_exwe) found = 1'b1;
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL reset_mid_write: no o_exwe within 20 cycles");
    end
    #1 rst_n = 1'b0;
    #1;
    done_cnt = 0;
    compared++;
    if ({o_exwe, o_busy, o_exa, o_exwd} !== '0) begin
      mismatched++;
      $display("FAIL reset_async: we=%b busy=%b exa=%h exwd=%h expected all 0", o_exwe, o_busy, o_exa, o_exwd);
    end
    i_vld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (done_cnt != 0 || o_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_abandon: done_count=%0d busy=%b expected 0 / 0", done_cnt, o_busy);
    end
    fill_words(48);
    run_load(4'($urandom), 5'd20, 1'($urandom), -1, 0, 1'b0, 1'b0, "clamp_16");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_verify = 1'b0;
    i_base = 4'd0; i_count = 5'd0; i_vld = 1'b0; i_data = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_verify();
    test_corrupt();
    test_stall_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
